mos6502_interrupt_sequencer: RTL and testbench
==============================================

# mos6502_interrupt_sequencer

Drives the 7-cycle interrupt-entry sequence of the MOS6502 core for RESET, NMI, IRQ and BRK. It arbitrates pending sources at an instruction boundary, generates the bus cycles that push PC and P and fetch the vector, and applies NMI hijack. It handshakes with the interrupt-request logic and sits between it and the core's address/data path multiplexers.

## Interface
Parameters:
- `STACK_PAGE`, default 8'h01: high address byte for stack pushes.

Ports (clock, reset first):
- `clk`  in  1  system clock; the single clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  CPU cycle enable; state advances only when high.
- `BOUNDARY`  in  1  core is at instruction boundary (T0, last cycle of instruction).
- `BRK_op`  in  1  opcode just fetched is BRK (valid with `BOUNDARY`).
- `nNMI_req`  in  1  pending NMI, active low.
- `nIRQ_req`  in  1  pending IRQ, active low, already masked by I.
- `PC`  in  16  current program counter.
- `SP`  in  8  current stack pointer.
- `P`  in  8  current status register.
- `BUSY`  out  1  sequence in progress; core datapath yields the bus.
- `ADDR`  out  16  bus address during sequence.
- `DOUT`  out  8  write data.
- `RnW`  out  1  1 = read, 0 = write.
- `SP_dec`  out  1  decrement SP this cycle.
- `PCL_load`, `PCH_load`  out  1  load PC byte from data bus.
- `PC_inc`  out  1  BRK signature-byte skip.
- `I_set`  out  1  set I flag.
- `NMI_ack`  out  1  one-cycle pulse; NMI consumed.
- `SRC`  out  2  active source: 0 BRK, 1 IRQ, 2 NMI, 3 RESET.

## Operation
- States: IDLE, S1 (dummy read PC), S2 (push PCH), S3 (push PCL), S4 (push P), S5 (read vector low), S6 (read vector high), then IDLE.
- RESET asserted: state IDLE, `res_pending` = 1, all strobes 0, `RnW` = 1, `BUSY` = 0, `ADDR` = 0, `DOUT` = 0, `SRC` = 3. The first `clk_en` after release enters S1 with SRC=RESET, without waiting for `BOUNDARY`.
- From IDLE, on `clk_en & BOUNDARY`, the source is chosen by fixed priority RESET > NMI > IRQ > BRK. No source pending: stay IDLE.
- S1: `ADDR`=PC, read. `PC_inc`=1 only for BRK.
- S2–S4: `ADDR`={STACK_PAGE,SP}, `SP_dec`=1. DOUT is PCH, PCL and P respectively.
  - For RESET, the cycles are reads (`RnW`=1) but SP still decrements.
  - Pushed P has bit5=1. Bit4 (B)=1 for BRK, 0 otherwise.
- Vector base: NMI 16'hFFFA, RESET 16'hFFFC, IRQ/BRK 16'hFFFE.
  - S5: read base, `PCL_load`=1.
  - S6: read base+1, `PCH_load`=1, `I_set`=1.
- NMI hijack: if `nNMI_req`=0 on the S4 enable edge and SRC is IRQ or BRK, the vector switches to FFFA and SRC becomes NMI. The already-pushed B stands.
- `NMI_ack` pulses in S5 whenever the vector used is FFFA.
- `res_pending` clears on entering S1.

## Timing
- Outputs are registered from state and held for a full enabled cycle. Strobes are asserted only while the matching state is current.
- With `clk_en` low, state and outputs hold and no new pulses are generated. `NMI_ack` is gated by `clk_en`.
- Exactly 6 enabled cycles from IDLE exit to IDLE return. `BUSY` rises on the edge leaving IDLE and falls on the edge leaving S6.
- An NMI arriving after S4 is not taken and stays pending. The next `BOUNDARY` is the first instruction boundary after the sequence.
- `BOUNDARY` while BUSY is ignored.
- RESET mid-sequence aborts immediately to reset values. Partial pushes are not undone.

## Structure
- `MOS6502.vh` holds the shared definitions:
  - source codes, state encodings and the three vector addresses;
  - `STACK_PAGE` default;
  - status bit indices for B, bit5 and I.
- Single module; no sub-module. The vector mux stays inline.

## Test plan
- Release RESET, `clk_en`=1, SP=8'hFD → reads at 01FD/01FC/01FB with RnW=1, reads at FFFC/FFFD, SP_dec ×3, I_set in S6, SRC=3.
- BOUNDARY with BRK_op=1, PC=16'h1234, SP=8'hFF, P=8'h00 → writes 12@01FF, 34@01FE, 30@01FD, vectors FFFE/FFFF, PC_inc in S1.
- IRQ (`nIRQ_req`=0) with NMI pending at the same boundary → SRC=2, pushed P=8'h20, vector FFFA, NMI_ack in S5.
- IRQ sequence with `nNMI_req` falling during S3 → vector FFFA, SRC changes to 2, NMI_ack pulses. The same stimulus falling during S5 → vector FFFE, NMI stays pending.
- `clk_en` toggling 1/0 during a BRK sequence → 12 clocks, identical bus trace, no duplicated strobes.
- RESET asserted in S3 → next clock BUSY=0 and RnW=1, then a full reset sequence after release.

Source files
------------

// File: rtl/mos6502_interrupt_sequencer_pkg.sv
// Shared definitions for the 6502 interrupt-entry sequencer: source codes,
// state encodings, vector addresses and status-register bit positions.
package mos6502_interrupt_sequencer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] STACK_PAGE_DEFAULT = 8'h01;

  // Active interrupt source, ordered so that a larger code wins arbitration
  typedef enum logic [1:0] {
    SRC_BRK   = 2'd0,
    SRC_IRQ   = 2'd1,
    SRC_NMI   = 2'd2,
    SRC_RESET = 2'd3
  } src_e;

  // Seven-step entry sequence: idle plus six bus cycles
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_S6   = 3'd6
  } state_e;

  localparam logic [ADDR_W-1:0] VEC_NMI   = 16'hFFFA;
  localparam logic [ADDR_W-1:0] VEC_RESET = 16'hFFFC;
  localparam logic [ADDR_W-1:0] VEC_IRQ   = 16'hFFFE;

  // Status register bit positions touched by the push of P
  localparam logic [2:0] P_BIT_B = 3'd4;
  localparam logic [2:0] P_BIT_5 = 3'd5;

  // Vector low-byte address for a given source (IRQ and BRK share one)
  function automatic logic [ADDR_W-1:0] vector_of(input src_e src);
    logic [ADDR_W-1:0] v;
    unique case (src)
      SRC_NMI:   v = VEC_NMI;
      SRC_RESET: v = VEC_RESET;
      default:   v = VEC_IRQ;
    endcase
    return v;
  endfunction

  // Status byte as pushed: bit 5 always set, B reflects whether BRK caused entry
  function automatic logic [DATA_W-1:0] push_status(input logic [DATA_W-1:0] p,
                                                    input logic              is_brk);
    logic [DATA_W-1:0] r;
    r          = p;
    r[P_BIT_5] = 1'b1;
    r[P_BIT_B] = is_brk;
    return r;
  endfunction

endpackage

// File: rtl/mos6502_interrupt_sequencer.sv
// MOS6502 interrupt-entry sequencer: arbitrates RESET/NMI/IRQ/BRK at an
// instruction boundary, then drives the six bus cycles that push PC and P
// and fetch the vector, including NMI hijack of an IRQ/BRK entry.
module mos6502_interrupt_sequencer
  import mos6502_interrupt_sequencer_pkg::*;
#(
  parameter logic [DATA_W-1:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              clk_en,
  input  logic              BOUNDARY,
  input  logic              BRK_op,
  input  logic              nNMI_req,
  input  logic              nIRQ_req,
  input  logic [ADDR_W-1:0] PC,
  input  logic [DATA_W-1:0] SP,
  input  logic [DATA_W-1:0] P,
  output logic              BUSY,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              RnW,
  output logic              SP_dec,
  output logic              PCL_load,
  output logic              PCH_load,
  output logic              PC_inc,
  output logic              I_set,
  output logic              NMI_ack,
  output logic [1:0]        SRC
);

  state_e            state_q;
  src_e              src_q;
  logic              res_pending_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] sp_q;
  logic [DATA_W-1:0] p_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              rnw_q;
  logic              sp_dec_q;
  logic              pcl_load_q;
  logic              pch_load_q;
  logic              pc_inc_q;
  logic              i_set_q;
  logic              nmi_ack_q;

  logic              take_d;
  src_e              src_d;
  logic              hijack_d;
  logic [ADDR_W-1:0] vec_d;

  // Fixed-priority source selection; a pending reset does not wait for a boundary
  always_comb begin
    take_d = 1'b0;
    src_d  = SRC_BRK;
    if (res_pending_q) begin
      take_d = 1'b1;
      src_d  = SRC_RESET;
    end else if (BOUNDARY) begin
      if (!nNMI_req) begin
        take_d = 1'b1;
        src_d  = SRC_NMI;
      end else if (!nIRQ_req) begin
        take_d = 1'b1;
        src_d  = SRC_IRQ;
      end else if (BRK_op) begin
        take_d = 1'b1;
        src_d  = SRC_BRK;
      end
    end
  end

  // Vector choice at the end of S4; a late NMI steals an IRQ/BRK entry
  always_comb begin
    hijack_d = !nNMI_req && ((src_q == SRC_IRQ) || (src_q == SRC_BRK));
    vec_d    = hijack_d ? VEC_NMI : vector_of(src_q);
  end

  // Sequencer FSM; every output is registered for the state being entered
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_RESET;
      res_pending_q <= 1'b1;
      pc_q          <= '0;
      sp_q          <= '0;
      p_q           <= '0;
      busy_q        <= 1'b0;
      addr_q        <= '0;
      dout_q        <= '0;
      rnw_q         <= 1'b1;
      sp_dec_q      <= 1'b0;
      pcl_load_q    <= 1'b0;
      pch_load_q    <= 1'b0;
      pc_inc_q      <= 1'b0;
      i_set_q       <= 1'b0;
      nmi_ack_q     <= 1'b0;
    end else if (clk_en) begin
      sp_dec_q   <= 1'b0;
      pcl_load_q <= 1'b0;
      pch_load_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      i_set_q    <= 1'b0;
      nmi_ack_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (take_d) begin
            state_q       <= ST_S1;
            src_q         <= src_d;
            res_pending_q <= 1'b0;
            pc_q          <= PC;
            sp_q          <= SP;
            p_q           <= push_status(P, src_d == SRC_BRK);
            busy_q        <= 1'b1;
            addr_q        <= PC;
            rnw_q         <= 1'b1;
            pc_inc_q      <= (src_d == SRC_BRK);
          end
        end
        ST_S1: begin
          state_q  <= ST_S2;
          addr_q   <= {STACK_PAGE, sp_q};
          dout_q   <= pc_q[15:8];
          rnw_q    <= (src_q == SRC_RESET);
          sp_dec_q <= 1'b1;
        end
        ST_S2: begin
          state_q  <= ST_S3;
          addr_q   <= {STACK_PAGE, DATA_W'(sp_q - 8'd1)};
          dout_q   <= pc_q[7:0];
          rnw_q    <= (src_q == SRC_RESET);
          sp_dec_q <= 1'b1;
        end
        ST_S3: begin
          state_q  <= ST_S4;
          addr_q   <= {STACK_PAGE, DATA_W'(sp_q - 8'd2)};
          dout_q   <= p_q;
          rnw_q    <= (src_q == SRC_RESET);
          sp_dec_q <= 1'b1;
        end
        ST_S4: begin
          state_q    <= ST_S5;
          if (hijack_d) src_q <= SRC_NMI;
          addr_q     <= vec_d;
          dout_q     <= '0;
          rnw_q      <= 1'b1;
          pcl_load_q <= 1'b1;
          nmi_ack_q  <= (vec_d == VEC_NMI);
        end
        ST_S5: begin
          state_q    <= ST_S6;
          addr_q     <= ADDR_W'(addr_q + 16'd1);
          pch_load_q <= 1'b1;
          i_set_q    <= 1'b1;
        end
        ST_S6: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          dout_q  <= '0;
          rnw_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          rnw_q   <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign ADDR     = addr_q;
  assign DOUT     = dout_q;
  assign RnW      = rnw_q;
  assign SP_dec   = sp_dec_q;
  assign PCL_load = pcl_load_q;
  assign PCH_load = pch_load_q;
  assign PC_inc   = pc_inc_q;
  assign I_set    = i_set_q;
  assign SRC      = src_q;
  // Acknowledge only in the cycle that actually consumes S5
  assign NMI_ack  = nmi_ack_q & clk_en;

endmodule

// File: tb/tb_mos6502_interrupt_sequencer.sv
// Self-checking bench for the 6502 interrupt-entry sequencer. A slot-indexed
// reference model predicts the six bus cycles of each entry from the source,
// PC, SP, P and the moment a late NMI request arrives.
module tb_mos6502_interrupt_sequencer;

  logic        clk;
  logic        RESET;
  logic        clk_en;
  logic        BOUNDARY;
  logic        BRK_op;
  logic        nNMI_req;
  logic        nIRQ_req;
  logic [15:0] PC;
  logic [7:0]  SP;
  logic [7:0]  P;
  logic        BUSY;
  logic [15:0] ADDR;
  logic [7:0]  DOUT;
  logic        RnW;
  logic        SP_dec;
  logic        PCL_load;
  logic        PCH_load;
  logic        PC_inc;
  logic        I_set;
  logic        NMI_ack;
  logic [1:0]  SRC;

  int n_cmp;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mos6502_interrupt_sequencer #(.STACK_PAGE(8'h01)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .clk_en   (clk_en),
    .BOUNDARY (BOUNDARY),
    .BRK_op   (BRK_op),
    .nNMI_req (nNMI_req),
    .nIRQ_req (nIRQ_req),
    .PC       (PC),
    .SP       (SP),
    .P        (P),
    .BUSY     (BUSY),
    .ADDR     (ADDR),
    .DOUT     (DOUT),
    .RnW      (RnW),
    .SP_dec   (SP_dec),
    .PCL_load (PCL_load),
    .PCH_load (PCH_load),
    .PC_inc   (PC_inc),
    .I_set    (I_set),
    .NMI_ack  (NMI_ack),
    .SRC      (SRC)
  );

  function automatic logic [6:0] obs_strobes();
    return {BUSY, SP_dec, PCL_load, PCH_load, PC_inc, I_set, NMI_ack};
  endfunction

  // One complete entry sequence. drop = slot (1..6) in which nNMI_req falls, 0 = never.
  // mode 0: clk_en always 1, 1: alternating 0/1, 2: random.
  task automatic run_seq(input int src, input logic [15:0] pc, input logic [7:0] sp,
                         input logic [7:0] p, input int drop, input int mode,
                         input logic bnd, output int clocks);
    bit         hij;
    int         fsrc;
    int         vec;
    int         slot;
    bit         en;
    bit         ack_clear;
    int         n_dec, n_pcl, n_pch, n_inc, n_iset, n_ack;
    int         e_addr;
    int         e_dout;
    bit         e_rnw;
    logic [6:0] e_stb;
    int         e_src;
    int         pushp;

    hij   = (drop >= 1) && (drop <= 4) && ((src == 0) || (src == 1));
    fsrc  = hij ? 2 : src;
    vec   = (fsrc == 2) ? 'hFFFA : (fsrc == 3) ? 'hFFFC : 'hFFFE;
    pushp = (int'(p) & 'hCF) | 'h20 | ((src == 0) ? 'h10 : 0);
    n_dec = 0; n_pcl = 0; n_pch = 0; n_inc = 0; n_iset = 0; n_ack = 0;

    @(negedge clk);
    PC = pc; SP = sp; P = p; BOUNDARY = bnd; clk_en = 1'b1;
    @(posedge clk);
    slot = 1; clocks = 0; ack_clear = 1'b0;
    while (slot <= 6 && clocks < 200) begin
      @(negedge clk);
      if (ack_clear) nNMI_req = 1'b1;
      if (drop == slot) nNMI_req = 1'b0;
      nIRQ_req = 1'b1;
      BOUNDARY = 1'($urandom_range(0, 1));
      BRK_op   = 1'($urandom_range(0, 1));
      case (mode)
        0:       en = 1'b1;
        1:       en = (clocks % 2 == 1);
        default: en = ($urandom_range(0, 2) != 0);
      endcase
      clk_en = en;
      #1;
      case (slot)
        1:       e_addr = int'(pc);
        2, 3, 4: e_addr = 'h0100 + ((int'(sp) - (slot - 2)) & 'hFF);
        5:       e_addr = vec;
        default: e_addr = vec + 1;
      endcase
      e_rnw  = (slot >= 2 && slot <= 4) ? (src == 3) : 1'b1;
      e_dout = (slot == 2) ? (int'(pc) >> 8) : (slot == 3) ? (int'(pc) & 'hFF) : pushp;
      e_stb  = {1'b1, (slot >= 2 && slot <= 4), (slot == 5), (slot == 6),
                (slot == 1 && src == 0), (slot == 6), (slot == 5 && vec == 'hFFFA && en)};
      e_src  = (slot <= 4) ? src : fsrc;

      n_cmp++;
      if (ADDR !== 16'(e_addr)) begin
        n_fail++;
        $display("FAIL addr slot %0d: got %h expected %h", slot, ADDR, 16'(e_addr));
      end
      n_cmp++;
      if (RnW !== e_rnw) begin
        n_fail++;
        $display("FAIL rnw slot %0d: got %b expected %b", slot, RnW, e_rnw);
      end
      if (!e_rnw) begin
        n_cmp++;
        if (DOUT !== 8'(e_dout)) begin
          n_fail++;
          $display("FAIL dout slot %0d: got %h expected %h", slot, DOUT, 8'(e_dout));
        end
      end
      n_cmp++;
      if (obs_strobes() !== e_stb) begin
        n_fail++;
        $display("FAIL strobes slot %0d en %0b: got %b expected %b (busy,spdec,pcl,pch,pcinc,iset,ack)",
                 slot, en, obs_strobes(), e_stb);
      end
      n_cmp++;
      if (SRC !== 2'(e_src)) begin
        n_fail++;
        $display("FAIL src slot %0d: got %0d expected %0d", slot, SRC, e_src);
      end

      if (en) begin
        n_dec  += int'(SP_dec);
        n_pcl  += int'(PCL_load);
        n_pch  += int'(PCH_load);
        n_inc  += int'(PC_inc);
        n_iset += int'(I_set);
      end
      n_ack += int'(NMI_ack);
      if (NMI_ack) ack_clear = 1'b1;
      @(posedge clk);
      clocks++;
      if (en) slot++;
    end
    if (clocks >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL seq_timeout: got %0d clocks expected completion", clocks);
    end

    n_cmp++;
    if (n_dec != 3 || n_pcl != 1 || n_pch != 1 || n_iset != 1 ||
        n_inc != int'(src == 0) || n_ack != int'(vec == 'hFFFA)) begin
      n_fail++;
      $display("FAIL strobe_counts: got dec=%0d pcl=%0d pch=%0d iset=%0d inc=%0d ack=%0d expected 3 1 1 1 %0d %0d",
               n_dec, n_pcl, n_pch, n_iset, n_inc, n_ack, int'(src == 0), int'(vec == 'hFFFA));
    end

    // Back in IDLE: bus released, last source retained
    @(negedge clk);
    if (ack_clear) nNMI_req = 1'b1;
    BOUNDARY = 1'b0; BRK_op = 1'b0; clk_en = 1'b1;
    #1;
    n_cmp++;
    if (obs_strobes() !== 7'b0 || RnW !== 1'b1 || ADDR !== 16'h0000 || SRC !== 2'(fsrc)) begin
      n_fail++;
      $display("FAIL idle_after: got stb=%b rnw=%b addr=%h src=%0d expected 0000000 1 0000 %0d",
               obs_strobes(), RnW, ADDR, SRC, fsrc);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b expected 0", BUSY);
    end
  endtask

  task automatic test_reset();
    int clocks;
    RESET = 1'b1; clk_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs_strobes() !== 7'b0 || RnW !== 1'b1 || ADDR !== 16'h0000 || DOUT !== 8'h00 || SRC !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_values: got stb=%b rnw=%b addr=%h dout=%h src=%0d expected 0000000 1 0000 00 3",
               obs_strobes(), RnW, ADDR, DOUT, SRC);
    end
    RESET = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wait_en: got busy=%b expected 0", BUSY);
    end
    run_seq(3, 16'hC000, 8'hFD, 8'h00, 0, 0, 1'b0, clocks);
    n_cmp++;
    if (clocks != 6) begin
      n_fail++;
      $display("FAIL reset_len: got %0d expected 6", clocks);
    end
  endtask

  task automatic test_brk();
    int clocks;
    nNMI_req = 1'b1; nIRQ_req = 1'b1; BRK_op = 1'b1;
    run_seq(0, 16'h1234, 8'hFF, 8'h00, 0, 0, 1'b1, clocks);
  endtask

  task automatic test_irq_with_nmi();
    int clocks;
    nNMI_req = 1'b0; nIRQ_req = 1'b0; BRK_op = 1'b0;
    run_seq(2, 16'h4321, 8'hF0, 8'h00, 0, 0, 1'b1, clocks);
  endtask

  task automatic test_nmi_hijack();
    int clocks;
    nNMI_req = 1'b1; nIRQ_req = 1'b0; BRK_op = 1'b0;
    run_seq(1, 16'h2000, 8'hE0, 8'hC3, 3, 0, 1'b1, clocks);
    // Late NMI: not taken, stays pending for the next boundary
    nNMI_req = 1'b1; nIRQ_req = 1'b0;
    run_seq(1, 16'h3000, 8'hD0, 8'h81, 5, 0, 1'b1, clocks);
    n_cmp++;
    if (nNMI_req !== 1'b0) begin
      n_fail++;
      $display("FAIL late_nmi_pending: got nNMI_req=%b expected 0", nNMI_req);
    end
    run_seq(2, 16'h3002, 8'hCD, 8'h81, 0, 0, 1'b1, clocks);
  endtask

  task automatic test_clk_en_toggle();
    int clocks;
    nNMI_req = 1'b1; nIRQ_req = 1'b1; BRK_op = 1'b1;
    run_seq(0, 16'h1234, 8'hFF, 8'h00, 0, 1, 1'b1, clocks);
    n_cmp++;
    if (clocks != 12) begin
      n_fail++;
      $display("FAIL toggle_len: got %0d clocks expected 12", clocks);
    end
  endtask

  task automatic test_reset_mid();
    int clocks;
    @(negedge clk);
    nNMI_req = 1'b1; nIRQ_req = 1'b0; BRK_op = 1'b0;
    PC = 16'hABCD; SP = 8'h80; P = 8'h00; BOUNDARY = 1'b1; clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nIRQ_req = 1'b1; BOUNDARY = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (ADDR !== 16'h017F || SP_dec !== 1'b1 || RnW !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_s3: got addr=%h spdec=%b rnw=%b expected 017F 1 0", ADDR, SP_dec, RnW);
    end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (obs_strobes() !== 7'b0 || RnW !== 1'b1 || ADDR !== 16'h0000 || SRC !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_reset: got stb=%b rnw=%b addr=%h src=%0d expected 0000000 1 0000 3",
               obs_strobes(), RnW, ADDR, SRC);
    end
    @(posedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    RESET  = 1'b0;
    run_seq(3, 16'h0000, 8'h7E, 8'h00, 0, 0, 1'b0, clocks);
  endtask

  task automatic test_random();
    int          clocks;
    int          esrc;
    int          drop;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  p;
    for (int i = 0; i < 40; i++) begin
      pc       = 16'($urandom);
      sp       = 8'($urandom);
      p        = 8'($urandom);
      nNMI_req = ($urandom_range(0, 3) != 0);
      nIRQ_req = 1'($urandom_range(0, 1));
      BRK_op   = 1'($urandom_range(0, 1));
      if (!nNMI_req)      esrc = 2;
      else if (!nIRQ_req) esrc = 1;
      else if (BRK_op)    esrc = 0;
      else                esrc = -1;
      drop = nNMI_req ? $urandom_range(0, 6) : 0;
      if (esrc < 0) begin
        @(negedge clk);
        BOUNDARY = 1'b1; clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (BUSY !== 1'b0) begin
          n_fail++;
          $display("FAIL no_source iter %0d: got busy=%b expected 0", i, BUSY);
        end
        BOUNDARY = 1'b0;
      end else begin
        run_seq(esrc, pc, sp, p, drop, 2, 1'b1, clocks);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    RESET = 1'b1; clk_en = 1'b0; BOUNDARY = 1'b0; BRK_op = 1'b0;
    nNMI_req = 1'b1; nIRQ_req = 1'b1; PC = '0; SP = '0; P = '0;
    test_reset();
    test_brk();
    test_irq_with_nmi();
    test_nmi_hijack();
    test_clk_en_toggle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
